mdr_issuer: RTL and testbench

Initiator-side sequencer for the multiply/divide/root (MDR) core. It accepts one operation request at a time on an upstream valid/ready channel and drives the core's operand and enable inputs. It then waits for the core's done strobe, captures the result and remainder, and holds them on a downstream valid/ready channel until they are consumed. It sits between the bus/command front-end and the MDR core, and owns all operand-validity checking so the core never receives an illegal operation.

---
 rtl/system_mdr_pkg.sv | 41 ++++
 rtl/mdr_watchdog.sv | 38 +++
 rtl/mdr_issuer.sv | 158 +++++++++++++++
 tb/tb_mdr_issuer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/system_mdr_pkg.sv
// Shared types and constants for the multiply/divide/root (MDR) issuer and core.
// Operation codes, one-hot core enables, issuer FSM states and the data width.
package system_mdr_pkg;

   localparam int DW = 16;

   typedef logic [DW-1:0] data_t;

   typedef enum logic [1:0] {
      OP_MULT = 2'd0,
      OP_DIV  = 2'd1,
      OP_ROOT = 2'd2,
      OP_RSVD = 2'd3
   } op_t;

   typedef logic [2:0] enb_t;

   localparam enb_t ENB_MULT = 3'b001;
   localparam enb_t ENB_DIV  = 3'b010;
   localparam enb_t ENB_ROOT = 3'b100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } mdr_state_t;

   // Reserved op maps to no enable so the core can never be started by it.
   function automatic enb_t op_enb(input op_t op);
      enb_t enb;
      case (op)
         OP_MULT: enb = ENB_MULT;
         OP_DIV:  enb = ENB_DIV;
         OP_ROOT: enb = ENB_ROOT;
         default: enb = '0;
      endcase
      return enb;
   endfunction

endpackage

// File: rtl/mdr_watchdog.sv
// Cycle counter that flags expiry when a running count would reach LIMIT.
// Only instantiated by mdr_issuer when MDR_TIMEOUT_EN is defined.
module mdr_watchdog #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (clear) begin
         count_next = '0;
      end else if (run && (count_reg != CW'(LIMIT))) begin
         count_next = count_reg + 1'b1;
      end
   end

   // Expiry is raised on the cycle whose closing edge brings the count to LIMIT.
   assign expired = run && (count_reg == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/mdr_issuer.sv
// Initiator-side sequencer for the MDR core: accepts one request, starts the core, returns the result.
// Optional done-timeout watchdog is built when MDR_TIMEOUT_EN is defined.
module mdr_issuer
   import system_mdr_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  i_valid,
   output logic  o_ready,
   input  op_t   i_op,
   input  data_t i_dataX,
   input  data_t i_dataY,
   output data_t o_dataX,
   output data_t o_dataY,
   output enb_t  o_enable,
   input  logic  i_done,
   input  data_t i_result,
   input  data_t i_remainder,
   output logic  o_valid,
   input  logic  i_ready,
   output data_t o_result,
   output data_t o_remainder,
   output logic  o_error
);

   mdr_state_t state_reg, state_next;
   op_t        op_reg, op_next;
   data_t      x_reg, x_next;
   data_t      y_reg, y_next;
   data_t      result_reg, result_next;
   data_t      rem_reg, rem_next;
   logic       error_reg, error_next;
   logic       live_reg;
   logic       accept;
   logic       wd_expired;

   // live_reg keeps o_ready low for the cycle following a reset edge.
   assign o_ready  = live_reg && (state_reg == IDLE);
   assign accept   = i_valid && o_ready;

   assign o_dataX     = x_reg;
   assign o_dataY     = y_reg;
   assign o_enable    = (state_reg == ISSUE) ? op_enb(op_reg) : '0;
   assign o_valid     = (state_reg == RESP);
   assign o_result    = result_reg;
   assign o_remainder = rem_reg;
   assign o_error     = error_reg;

`ifdef MDR_TIMEOUT_EN
   logic wd_run;

   assign wd_run = (state_reg == ISSUE) || (state_reg == WAIT);

   mdr_watchdog #(
      .LIMIT   (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept),
      .run     (wd_run),
      .expired (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      x_next      = x_reg;
      y_next      = y_reg;
      result_next = result_reg;
      rem_next    = rem_reg;
      error_next  = error_reg;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               op_next = i_op;
               x_next  = i_dataX;
               y_next  = (i_op == OP_ROOT) ? '0 : i_dataY;
               case (i_op)
                  OP_MULT, OP_ROOT: begin
                     state_next = ISSUE;
                  end
                  OP_DIV: begin
                     if (i_dataY == '0) begin
                        state_next  = RESP;
                        error_next  = 1'b1;
                        result_next = '1;
                        rem_next    = i_dataX;
                     end else begin
                        state_next = ISSUE;
                     end
                  end
                  default: begin
                     state_next  = RESP;
                     error_next  = 1'b1;
                     result_next = '0;
                     rem_next    = '0;
                  end
               endcase
            end
         end

         // Completion is accepted in ISSUE as well; done beats a coincident timeout.
         ISSUE, WAIT: begin
            state_next = WAIT;
            if (i_done) begin
               state_next  = RESP;
               error_next  = 1'b0;
               result_next = i_result;
               rem_next    = i_remainder;
            end else if (wd_expired) begin
               state_next  = RESP;
               error_next  = 1'b1;
               result_next = '0;
               rem_next    = '0;
            end
         end

         RESP: begin
            if (i_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= IDLE;
         op_reg     <= OP_MULT;
         x_reg      <= '0;
         y_reg      <= '0;
         result_reg <= '0;
         rem_reg    <= '0;
         error_reg  <= 1'b0;
         live_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         op_reg     <= op_next;
         x_reg      <= x_next;
         y_reg      <= y_next;
         result_reg <= result_next;
         rem_reg    <= rem_next;
         error_reg  <= error_next;
         live_reg   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mdr_issuer.sv
// Directed self-checking bench for mdr_issuer; the core is emulated by driving i_done/i_result.
// Timeout scenarios run only when MDR_TIMEOUT_EN is defined.
module tb_mdr_issuer;
   import system_mdr_pkg::*;

   logic  clk;
   logic  rst;
   logic  i_valid;
   logic  o_ready;
   op_t   i_op;
   data_t i_dataX;
   data_t i_dataY;
   data_t o_dataX;
   data_t o_dataY;
   enb_t  o_enable;
   logic  i_done;
   data_t i_result;
   data_t i_remainder;
   logic  o_valid;
   logic  i_ready;
   data_t o_result;
   data_t o_remainder;
   logic  o_error;

   int tests_run    = 0;
   int tests_failed = 0;

   mdr_issuer #(
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_op        (i_op),
      .i_dataX     (i_dataX),
      .i_dataY     (i_dataY),
      .o_dataX     (o_dataX),
      .o_dataY     (o_dataY),
      .o_enable    (o_enable),
      .i_done      (i_done),
      .i_result    (i_result),
      .i_remainder (i_remainder),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_result    (o_result),
      .o_remainder (o_remainder),
      .o_error     (o_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present a request at a negedge, emulate the core, and check the response.
   // lat < 0 means the core never signals done; exp_vlat is cycles from accept+1 to o_valid.
   task automatic do_op(input string tag, input op_t op, input data_t x, input data_t y,
                        input int lat, input data_t cres, input data_t crem,
                        input enb_t exp_enb, input int exp_vlat,
                        input data_t exp_res, input data_t exp_rem, input logic exp_err);
      int k;
      int en_cycles;
      i_valid = 1'b1;
      i_op    = op;
      i_dataX = x;
      i_dataY = y;
      check({tag, " ready"}, o_ready, 1);
      @(negedge clk);
      i_valid = 1'b0;
      k = 0;
      en_cycles = 0;
      while (!o_valid && k < 200) begin
         if (o_enable != '0) begin
            en_cycles++;
            check({tag, " enable"}, o_enable, exp_enb);
         end
         if (k == lat) begin
            i_done      = 1'b1;
            i_result    = cres;
            i_remainder = crem;
         end
         @(negedge clk);
         i_done = 1'b0;
         k++;
      end
      check({tag, " valid_lat"}, k, exp_vlat);
      check({tag, " enb_cycles"}, en_cycles, (exp_enb != '0) ? 1 : 0);
      check({tag, " result"}, o_result, exp_res);
      check({tag, " remainder"}, o_remainder, exp_rem);
      check({tag, " error"}, o_error, exp_err);
      check({tag, " dataX"}, o_dataX, x);
      check({tag, " dataY"}, o_dataY, (op == OP_ROOT) ? '0 : y);
      $display("[TB] %s op=%0d X=%0d Y=%0d -> result=%0h rem=%0h err=%0b after %0d cycles",
               tag, op, x, y, o_result, o_remainder, o_error, k);
   endtask

   // Hold back-pressure for 'hold' cycles with stability checks, then consume.
   task automatic drain(input string tag, input int hold, input data_t exp_res,
                        input data_t exp_rem, input logic exp_err);
      i_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, " hold_valid"}, o_valid, 1);
         check({tag, " hold_ready"}, o_ready, 0);
         check({tag, " hold_result"}, o_result, exp_res);
         check({tag, " hold_rem"}, o_remainder, exp_rem);
         check({tag, " hold_err"}, o_error, exp_err);
      end
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      check({tag, " drained_valid"}, o_valid, 0);
      check({tag, " drained_ready"}, o_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      rst         = 1'b0;
      i_valid     = 1'b0;
      i_op        = OP_MULT;
      i_dataX     = '0;
      i_dataY     = '0;
      i_done      = 1'b0;
      i_result    = '0;
      i_remainder = '0;
      i_ready     = 1'b0;

      @(negedge clk);
      @(negedge clk);
      check("reset ready", o_ready, 0);
      check("reset valid", o_valid, 0);
      check("reset enable", o_enable, 0);
      check("reset error", o_error, 0);
      check("reset result", o_result, 0);
      check("reset dataX", o_dataX, 0);
      rst = 1'b1;
      @(negedge clk);
      check("post_reset ready", o_ready, 1);

      do_op("mult", OP_MULT, 16'd7, 16'd6, 4, 16'd42, 16'd0, ENB_MULT, 5, 16'd42, 16'd0, 1'b0);
      drain("mult", 0, 16'd42, 16'd0, 1'b0);

      do_op("div", OP_DIV, 16'd100, 16'd7, 2, 16'd14, 16'd2, ENB_DIV, 3, 16'd14, 16'd2, 1'b0);
      drain("div", 5, 16'd14, 16'd2, 1'b0);

      do_op("div0", OP_DIV, 16'd55, 16'd0, 0, 16'd9, 16'd9, 3'b000, 0, 16'hFFFF, 16'd55, 1'b1);
      drain("div0", 1, 16'hFFFF, 16'd55, 1'b1);

      do_op("root", OP_ROOT, 16'd50, 16'd9, 0, 16'd7, 16'd1, ENB_ROOT, 1, 16'd7, 16'd1, 1'b0);
      drain("root", 0, 16'd7, 16'd1, 1'b0);

      do_op("rsvd", OP_RSVD, 16'd12, 16'd34, 0, 16'd5, 16'd5, 3'b000, 0, 16'd0, 16'd0, 1'b1);
      drain("rsvd", 0, 16'd0, 16'd0, 1'b1);

      // Reset while the core is busy, then a stale done must be ignored.
      i_valid = 1'b1;
      i_op    = OP_MULT;
      i_dataX = 16'd3;
      i_dataY = 16'd5;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      check("midrst enable_off", o_enable, 0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst ready_in_reset", o_ready, 0);
      check("midrst dataX", o_dataX, 0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst ready", o_ready, 1);
      i_done   = 1'b1;
      i_result = 16'd99;
      @(negedge clk);
      i_done = 1'b0;
      @(negedge clk);
      check("midrst valid", o_valid, 0);
      check("midrst ready_after", o_ready, 1);
      check("midrst result", o_result, 0);
      check("midrst remainder", o_remainder, 0);
      check("midrst error", o_error, 0);
      check("midrst enable", o_enable, 0);
      check("midrst dataY", o_dataY, 0);
      $display("[TB] midrst reset during WAIT, stale done ignored");

`ifdef MDR_TIMEOUT_EN
      do_op("tmo", OP_MULT, 16'd2, 16'd3, -1, 16'd0, 16'd0, ENB_MULT, 64, 16'd0, 16'd0, 1'b1);
      drain("tmo", 0, 16'd0, 16'd0, 1'b1);
      do_op("tmo_done", OP_DIV, 16'd9, 16'd4, 63, 16'd1234, 16'd1, ENB_DIV, 64, 16'd1234, 16'd1, 1'b0);
      drain("tmo_done", 0, 16'd1234, 16'd1, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
